// File: rtl/sorter_if.sv
// Bundles the read side of the per-channel input FIFOs and the write side of
// the merged output FIFO for the sorter.
interface sorter_if #(
  parameter int CNO        = 8,
  parameter int DATA_WIDTH = 32
);
  logic [CNO*DATA_WIDTH-1:0] rdfifo_data_i;
  logic [CNO-1:0]            rdfifo_empty_i;
  logic [CNO-1:0]            rdfifo_rden_o;
  logic [DATA_WIDTH-1:0]     wrfifo_data_o;
  logic                      wrfifo_prog_full_i;
  logic                      wrfifo_wren_o;

  modport master (
    input  rdfifo_data_i,
    input  rdfifo_empty_i,
    input  wrfifo_prog_full_i,
    output rdfifo_rden_o,
    output wrfifo_data_o,
    output wrfifo_wren_o
  );

  modport slave (
    output rdfifo_data_i,
    output rdfifo_empty_i,
    output wrfifo_prog_full_i,
    input  rdfifo_rden_o,
    input  wrfifo_data_o,
    input  wrfifo_wren_o
  );
endinterface

// File: rtl/sorter.sv
// K-way merge of ascending per-channel FIFO streams into one ascending stream.
// Holds one head word per channel and emits the global minimum once every channel is resolved.
module sorter #(
  parameter int CNO           = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int EMPTY_TIMEOUT = 6
) (
  input  logic     clk,
  input  logic     rst,
  sorter_if.master bus
);
  localparam int TW = $clog2(EMPTY_TIMEOUT + 1);
  localparam int SW = $clog2(CNO);
  localparam logic [TW-1:0] TMAX = TW'(EMPTY_TIMEOUT);

  logic [DATA_WIDTH-1:0] head_q [CNO];
  logic [DATA_WIDTH-1:0] head_d [CNO];
  logic [TW-1:0]         tcnt_q [CNO];
  logic [TW-1:0]         tcnt_d [CNO];
  logic [CNO-1:0]        hv_q, hv_d;
  logic [CNO-1:0]        pend_q, pend_d;
  logic [CNO-1:0]        rden, resolved;
  logic                  wren_q, wren_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         sel;
  logic [DATA_WIDTH-1:0] sel_val;
  logic                  any_hv;
  logic                  emit;

  // A channel without a head only counts as resolved once it has sat empty long enough.
  always_comb begin
    rden     = '0;
    resolved = '0;
    for (int c = 0; c < CNO; c++) begin
      rden[c]     = ~rst & ~bus.rdfifo_empty_i[c] & ~hv_q[c] & ~pend_q[c];
      resolved[c] = hv_q[c] |
                    (~pend_q[c] & bus.rdfifo_empty_i[c] & (tcnt_q[c] == TMAX));
    end
  end

  // Strict less-than keeps the lowest index on equal heads.
  always_comb begin
    sel     = '0;
    sel_val = '0;
    any_hv  = 1'b0;
    for (int c = 0; c < CNO; c++) begin
      if (hv_q[c] && (!any_hv || head_q[c] < sel_val)) begin
        sel     = SW'(c);
        sel_val = head_q[c];
        any_hv  = 1'b1;
      end
    end
  end

  assign emit = (&resolved) & any_hv & ~bus.wrfifo_prog_full_i;

  always_comb begin
    pend_d  = rden;
    hv_d    = hv_q;
    wren_d  = emit;
    wdata_d = emit ? sel_val : wdata_q;
    for (int c = 0; c < CNO; c++) begin
      head_d[c] = head_q[c];
      tcnt_d[c] = '0;
      if (pend_q[c]) begin
        head_d[c] = bus.rdfifo_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        hv_d[c]   = 1'b1;
      end
      if (emit && sel == SW'(c)) begin
        hv_d[c] = 1'b0;
      end
      if (~hv_q[c] & ~pend_q[c] & bus.rdfifo_empty_i[c]) begin
        tcnt_d[c] = (tcnt_q[c] == TMAX) ? TMAX : tcnt_q[c] + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CNO; c++) begin
        head_q[c] <= '0;
        tcnt_q[c] <= '0;
      end
      hv_q    <= '0;
      pend_q  <= '0;
      wren_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tcnt_q  <= tcnt_d;
      hv_q    <= hv_d;
      pend_q  <= pend_d;
      wren_q  <= wren_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.rdfifo_rden_o = rden;
  assign bus.wrfifo_wren_o = wren_q;
  assign bus.wrfifo_data_o = wdata_q;
endmodule

// File: tb/tb_sorter.sv
// Directed bench for the sorter: behavioural non-FWFT FIFOs feed eight channels,
// and a negedge monitor collects every written word.
module tb_sorter;
  localparam int CNO = 8;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sorter_if #(.CNO(CNO), .DATA_WIDTH(DW)) bus ();

  sorter #(.CNO(CNO), .DATA_WIDTH(DW), .EMPTY_TIMEOUT(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0]  fifo_mem  [CNO][64];
  logic [DW-1:0]  fifo_data [CNO];
  int             wr_ptr    [CNO];
  int             rd_ptr    [CNO];
  logic [CNO-1:0] fifo_empty = '1;

  // Read data appears the cycle after rden; empty is registered so it never races the DUT.
  always @(posedge clk) begin : fifo_model
    int nr;
    for (int c = 0; c < CNO; c++) begin
      nr = rd_ptr[c];
      if (bus.rdfifo_rden_o[c] && nr != wr_ptr[c]) begin
        fifo_data[c] <= fifo_mem[c][nr];
        nr++;
      end
      rd_ptr[c]     <= nr;
      fifo_empty[c] <= (nr == wr_ptr[c]);
    end
  end

  for (genvar g = 0; g < CNO; g++) begin : g_data
    assign bus.rdfifo_data_i[g*DW +: DW] = fifo_data[g];
  end
  assign bus.rdfifo_empty_i = fifo_empty;

  int            wren_count = 0;
  int            rden_count = 0;
  logic [DW-1:0] out_q [$];

  always @(negedge clk) begin
    if (bus.wrfifo_wren_o === 1'b1) begin
      out_q.push_back(bus.wrfifo_data_o);
      wren_count++;
    end
    if (bus.rdfifo_rden_o != '0) rden_count++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int c, input logic [DW-1:0] v);
    fifo_mem[c][wr_ptr[c]] = v;
    wr_ptr[c]++;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] outAt(input int idx);
    return (idx < out_q.size()) ? out_q[idx] : 'x;
  endfunction

  initial begin
    int wb, rb, ob, lat;
    logic [DW-1:0] exp_d [8]  = '{7, 12, 19, 25, 30, 41, 50, 60};
    logic [DW-1:0] vals_d[8]  = '{30, 12, 50, 7, 41, 19, 25, 60};
    logic [DW-1:0] exp_e [16] = '{1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 13, 14, 16, 17, 19, 21};

    bus.wrfifo_prog_full_i = 1'b0;

    // Reset state and all channels empty.
    rst = 1'b1;
    repeat (3) step();
    checkOutput("reset_wren", bus.wrfifo_wren_o, 0);
    checkOutput("reset_data", bus.wrfifo_data_o, 0);
    checkOutput("reset_rden", bus.rdfifo_rden_o, 0);
    checkOutput("reset_hv", dut.hv_q, 0);
    wb = wren_count;
    rb = rden_count;
    rst = 1'b0;
    repeat (20) step();
    checkOutput("empty_no_wren", wren_count - wb, 0);
    checkOutput("empty_no_rden", rden_count - rb, 0);
    for (int c = 0; c < CNO; c++) checkOutput($sformatf("empty_tcnt%0d", c), dut.tcnt_q[c], 6);

    // Single word on ch5: rden held off during reset, write after the others time out.
    rst = 1'b1;
    step();
    applyStimulus(5, 42);
    repeat (2) step();
    checkOutput("single_rden_in_reset", bus.rdfifo_rden_o, 0);
    wb = wren_count;
    ob = out_q.size();
    rst = 1'b0;
    lat = 0;
    while (wren_count == wb && lat < 30) begin
      step();
      lat++;
    end
    checkOutput("single_latency", lat, 7);
    checkOutput("single_data", outAt(ob), 42);
    repeat (15) step();
    checkOutput("single_count", wren_count - wb, 1);

    // Tie on value 5 between ch0 and ch3: ch0 goes first.
    rst = 1'b1;
    applyStimulus(0, 5);
    applyStimulus(0, 6);
    applyStimulus(3, 5);
    repeat (3) step();
    wb = wren_count;
    ob = out_q.size();
    rst = 1'b0;
    lat = 0;
    while (wren_count == wb && lat < 40) begin
      step();
      lat++;
    end
    checkOutput("tie_first_from_ch0", dut.hv_q[0], 0);
    checkOutput("tie_ch3_still_held", dut.hv_q[3], 1);
    repeat (30) step();
    checkOutput("tie_count", wren_count - wb, 3);
    checkOutput("tie_w0", outAt(ob), 5);
    checkOutput("tie_w1", outAt(ob + 1), 5);
    checkOutput("tie_w2", outAt(ob + 2), 6);

    // prog_full held with every head loaded, then released.
    bus.wrfifo_prog_full_i = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < CNO; c++) applyStimulus(c, vals_d[c]);
    repeat (3) step();
    wb = wren_count;
    ob = out_q.size();
    rst = 1'b0;
    repeat (20) step();
    checkOutput("pfull_no_wren", wren_count - wb, 0);
    checkOutput("pfull_heads_loaded", dut.hv_q, 8'hFF);
    bus.wrfifo_prog_full_i = 1'b0;
    step();
    checkOutput("pfull_release_wren", bus.wrfifo_wren_o, 1);
    checkOutput("pfull_release_data", bus.wrfifo_data_o, 7);
    repeat (80) step();
    checkOutput("pfull_count", wren_count - wb, 8);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("pfull_w%0d", i), outAt(ob + i), exp_d[i]);

    // Full merge with prog_full toggling.
    rst = 1'b1;
    applyStimulus(0, 1);  applyStimulus(0, 9);  applyStimulus(0, 17);
    applyStimulus(1, 2);  applyStimulus(1, 10);
    applyStimulus(3, 3);  applyStimulus(3, 11); applyStimulus(3, 19);
    applyStimulus(4, 4);
    applyStimulus(5, 6);  applyStimulus(5, 14);
    applyStimulus(6, 8);  applyStimulus(6, 16);
    applyStimulus(7, 5);  applyStimulus(7, 13); applyStimulus(7, 21);
    repeat (3) step();
    wb = wren_count;
    ob = out_q.size();
    rst = 1'b0;
    lat = 0;
    while (wren_count - wb < 16 && lat < 400) begin
      bus.wrfifo_prog_full_i = ((lat % 4) == 1) || ((lat % 7) == 3);
      step();
      lat++;
    end
    bus.wrfifo_prog_full_i = 1'b0;
    repeat (20) step();
    checkOutput("merge_count", wren_count - wb, 16);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("merge_w%0d", i), outAt(ob + i), exp_e[i]);

    // Reset while a read is in flight on ch2: the arriving word is dropped.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    applyStimulus(2, 77);
    repeat (2) step();
    checkOutput("rst_pend_set", dut.pend_q[2], 1);
    wb = wren_count;
    rst = 1'b1;
    step();
    checkOutput("rst_wren", bus.wrfifo_wren_o, 0);
    checkOutput("rst_hv", dut.hv_q, 0);
    checkOutput("rst_pend", dut.pend_q, 0);
    rst = 1'b0;
    repeat (20) step();
    checkOutput("rst_not_captured", dut.hv_q, 0);
    checkOutput("rst_no_write", wren_count - wb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
